nmi_arbiter: RTL and testbench

Round-robin arbiter that shares one NMI master port (valid/addr/wdata/wstrb/rdata/ready) between `NUM_MST` requesters. Typical requesters are the CPU core's bus port and a DMA engine. It sits between those masters and the SoC interconnect that decodes the memory map. Each granted transaction is registered and held to completion, with one arbitration cycle between transactions. An optional watchdog terminates transactions that the slave never acknowledges.

---
 rtl/nmi_arb_pkg.sv | 15 +
 rtl/nmi_if.sv | 13 +
 rtl/nmi_arbiter_rr_arbiter.sv | 37 +++
 rtl/nmi_arbiter.sv | 155 +++++++++++++++
 tb/tb_nmi_arbiter.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nmi_arb_pkg.sv
// nmi_arb_pkg: shared types and constants for the NMI master-port arbiter.
//   arb_state_e      : arbiter FSM states
//   NMI_ARB_ERR_DATA : read data returned on a watchdog-terminated transaction
//   NMI_ARB_MAX_MST  : largest supported requester count
package nmi_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   localparam logic [31:0] NMI_ARB_ERR_DATA = 32'hDEAD_BEEF;
   localparam int          NMI_ARB_MAX_MST  = 8;

endpackage

// File: rtl/nmi_if.sv
// nmi_if: single-master NMI bus (valid/addr/wdata/wstrb out, rdata/ready back).
//   wstrb == 0 denotes a read; ready completes the transfer in the same cycle.
interface nmi_if;
   logic        valid;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic [31:0] rdata;
   logic        ready;

   modport master (output valid, addr, wdata, wstrb, input rdata, ready);
   modport slave  (input valid, addr, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/nmi_arbiter_rr_arbiter.sv
// rr_arbiter: combinational rotating-priority picker.
//   req_i  : request vector
//   last_i : index of the most recent winner (lowest priority next round)
//   gnt_o  : one-hot winner, all zeros when nothing is requested
//   idx_o  : index of the winner (0 when nothing is requested)
module rr_arbiter #(
   parameter int NUM_MST = 2,
   parameter int IDX_W   = 1
) (
   input  logic [NUM_MST-1:0] req_i,
   input  logic [IDX_W-1:0]   last_i,
   output logic [NUM_MST-1:0] gnt_o,
   output logic [IDX_W-1:0]   idx_o
);

   localparam int unsigned N_U = NUM_MST;

   logic             found;
   logic [IDX_W-1:0] cand;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      cand  = '0;
      // Search upward starting just past the last winner, wrapping modulo N.
      for (int unsigned k = 1; k <= N_U; k++) begin
         cand = IDX_W'((32'(last_i) + k) % N_U);
         if (!found && req_i[cand]) begin
            found       = 1'b1;
            gnt_o[cand] = 1'b1;
            idx_o       = cand;
         end
      end
   end

endmodule

// File: rtl/nmi_arbiter.sv
// nmi_arbiter: round-robin sharing of one NMI master port among NUM_MST masters.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   mst_*_i        : per-master request, address, write data, byte strobes
//   mst_ready_o    : one-hot single-cycle completion to the owning master
//   mst_rdata_o    : shared read data, valid alongside mst_ready_o
//   grant_o        : registered one-hot owner, zero when idle
//   tmo_o          : one-cycle watchdog expiry pulse
//   nmi            : downstream NMI master port
// Optional feature: define NMI_ARB_TIMEOUT_EN to enable the watchdog that
// force-completes a transaction after TIMEOUT_CYC BUSY cycles with no ready.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no transaction; pick a requester and capture its request
// BUSY  | captured request driven downstream until ready (or watchdog)
module nmi_arbiter
   import nmi_arb_pkg::*;
#(
   parameter int NUM_MST     = 2,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic [NUM_MST-1:0]       mst_valid_i,
   input  logic [NUM_MST-1:0][31:0] mst_addr_i,
   input  logic [NUM_MST-1:0][31:0] mst_wdata_i,
   input  logic [NUM_MST-1:0][3:0]  mst_wstrb_i,
   output logic [NUM_MST-1:0]       mst_ready_o,
   output logic [31:0]              mst_rdata_o,
   output logic [NUM_MST-1:0]       grant_o,
   output logic                     tmo_o,
   nmi_if.master                    nmi
);

   localparam int IDX_W = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;

   // An unsupported parameterisation never grants rather than misbehaving.
   localparam bit CFG_OK = (NUM_MST >= 2) && (NUM_MST <= NMI_ARB_MAX_MST) &&
                           (TIMEOUT_CYC >= 2);

   arb_state_e         state_q, state_d;
   logic [NUM_MST-1:0] grant_q, grant_d;
   logic [IDX_W-1:0]   last_q, last_d;
   logic [31:0]        addr_q, addr_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [3:0]         wstrb_q, wstrb_d;

   logic [NUM_MST-1:0] req;
   logic [NUM_MST-1:0] pick_gnt;
   logic [IDX_W-1:0]   pick_idx;
   logic               busy;
   logic               done;
   logic               expire;

   assign req  = mst_valid_i & {NUM_MST{CFG_OK}};
   assign busy = (state_q == BUSY);

   rr_arbiter #(
      .NUM_MST (NUM_MST),
      .IDX_W   (IDX_W)
   ) u_rr (
      .req_i  (req),
      .last_i (last_q),
      .gnt_o  (pick_gnt),
      .idx_o  (pick_idx)
   );

`ifdef NMI_ARB_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC);

   logic [TMO_W-1:0] cnt_q, cnt_d;

   // Ready in the expiry cycle wins: no forced completion, no pulse.
   assign expire = busy && !nmi.ready && (cnt_q == TMO_W'(TIMEOUT_CYC - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (!busy) begin
         cnt_d = '0;
      end else if (!nmi.ready) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign expire = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (|req) begin
               state_d = BUSY;
               grant_d = pick_gnt;
               last_d  = pick_idx;
               addr_d  = mst_addr_i[pick_idx];
               wdata_d = mst_wdata_i[pick_idx];
               wstrb_d = mst_wstrb_i[pick_idx];
            end
         end
         BUSY: begin
            if (nmi.ready || expire) begin
               done    = 1'b1;
               state_d = IDLE;
               grant_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= IDX_W'(NUM_MST - 1);
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
      end
   end

   // Completion is returned combinationally in the ready cycle.
   assign mst_ready_o = done ? grant_q : '0;
   assign mst_rdata_o = expire ? NMI_ARB_ERR_DATA : nmi.rdata;
   assign tmo_o       = expire;
   assign grant_o     = grant_q;

   assign nmi.valid = busy;
   assign nmi.addr  = addr_q;
   assign nmi.wdata = wdata_q;
   assign nmi.wstrb = wstrb_q;

endmodule

// File: tb/tb_nmi_arbiter.sv
module tb_nmi_arbiter;
   localparam int NM  = 2;
   localparam int IW  = 1;
   localparam int TMO = 16;

   logic clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   logic                rst_n_i = 1'b0;
   logic [NM-1:0]       mst_valid_i;
   logic [NM-1:0][31:0] mst_addr_i;
   logic [NM-1:0][31:0] mst_wdata_i;
   logic [NM-1:0][3:0]  mst_wstrb_i;
   logic [NM-1:0]       mst_ready_o;
   logic [31:0]         mst_rdata_o;
   logic [NM-1:0]       grant_o;
   logic                tmo_o;
   logic                slv_ready;
   logic [31:0]         slv_rdata;

   nmi_if nmi ();
   assign nmi.ready = slv_ready;
   assign nmi.rdata = slv_rdata;

   nmi_arbiter #(.NUM_MST(NM), .TIMEOUT_CYC(TMO)) dut (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .mst_valid_i (mst_valid_i),
      .mst_addr_i  (mst_addr_i),
      .mst_wdata_i (mst_wdata_i),
      .mst_wstrb_i (mst_wstrb_i),
      .mst_ready_o (mst_ready_o),
      .mst_rdata_o (mst_rdata_o),
      .grant_o     (grant_o),
      .tmo_o       (tmo_o),
      .nmi         (nmi)
   );

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level reference: who owns the port, what was captured,
   // and at which cycle the ownership began.
   int            cyc;
   logic          m_busy;
   logic [IW-1:0] m_own, m_last;
   int            m_gcyc;
   logic [31:0]   m_addr, m_wdata;
   logic [3:0]    m_wstrb;

   function automatic logic [IW-1:0] pick(input logic [NM-1:0] req, input logic [IW-1:0] last);
      int c;
      for (int k = 1; k <= NM; k++) begin
         c = (int'(last) + k) % NM;
         if (((req >> c) & NM'(1)) != '0) return IW'(c);
      end
      return '0;
   endfunction

   function automatic bit m_expire();
`ifdef NMI_ARB_TIMEOUT_EN
      return m_busy && !slv_ready && ((cyc - m_gcyc) == TMO - 1);
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit m_done();
      return m_busy && (slv_ready || m_expire());
   endfunction

   function automatic logic [NM-1:0] m_gnt();
      return m_busy ? (NM'(1) << m_own) : NM'(0);
   endfunction

   always @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cyc    <= 0;
         m_busy <= 1'b0;
         m_own  <= '0;
         m_last <= IW'(NM - 1);
         m_gcyc <= 0;
      end else begin
         cyc <= cyc + 1;
         if (m_busy) begin
            if (m_done()) m_busy <= 1'b0;
         end else if (mst_valid_i != '0) begin
            m_busy  <= 1'b1;
            m_own   <= pick(mst_valid_i, m_last);
            m_last  <= pick(mst_valid_i, m_last);
            m_addr  <= mst_addr_i[pick(mst_valid_i, m_last)];
            m_wdata <= mst_wdata_i[pick(mst_valid_i, m_last)];
            m_wstrb <= mst_wstrb_i[pick(mst_valid_i, m_last)];
            m_gcyc  <= cyc + 1;
         end
      end
   end

   always @(negedge clk_i) begin
      if (chk_en && rst_n_i) begin
         chk("m_valid", 32'(nmi.valid), 32'(m_busy));
         chk("m_grant", 32'(grant_o), 32'(m_gnt()));
         if (m_busy) begin
            chk("m_addr", nmi.addr, m_addr);
            chk("m_wdata", nmi.wdata, m_wdata);
            chk("m_wstrb", 32'(nmi.wstrb), 32'(m_wstrb));
         end
         chk("m_ready", 32'(mst_ready_o), 32'(m_done() ? m_gnt() : NM'(0)));
         if (m_done()) chk("m_rdata", mst_rdata_o, m_expire() ? 32'hDEAD_BEEF : slv_rdata);
         chk("m_tmo", 32'(tmo_o), 32'(m_expire()));
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_n_i = 1'b0;
      tick();
      tick();
      rst_n_i = 1'b1;
   endtask

   logic [NM-1:0] cont_exp [8];
   int n_done;
   int n_tmo;

   initial begin
      mst_valid_i = '0;
      mst_addr_i  = '0;
      mst_wdata_i = '0;
      mst_wstrb_i = '0;
      slv_ready   = 1'b0;
      slv_rdata   = '0;
      tick();
      chk("rst_grant", 32'(grant_o), 32'h0);
      chk("rst_valid", 32'(nmi.valid), 32'h0);
      chk("rst_addr", nmi.addr, 32'h0);
      chk("rst_wdata", nmi.wdata, 32'h0);
      chk("rst_wstrb", 32'(nmi.wstrb), 32'h0);
      chk("rst_tmo", 32'(tmo_o), 32'h0);
      tick();
      rst_n_i = 1'b1;
      chk_en  = 1'b1;

      // Single master read, slave answers in cycle 4.
      mst_valid_i[0] = 1'b1;
      mst_addr_i[0]  = 32'h1000_0000;
      tick();
      chk("single_valid_c1", 32'(nmi.valid), 32'h1);
      chk("single_grant_c1", 32'(grant_o), 32'h1);
      chk("single_addr_c1", nmi.addr, 32'h1000_0000);
      tick();
      tick();
      tick();
      slv_ready = 1'b1;
      slv_rdata = 32'h1234_5678;
      #1;
      chk("single_ready_c4", 32'(mst_ready_o), 32'h1);
      chk("single_rdata_c4", mst_rdata_o, 32'h1234_5678);
      tick();
      mst_valid_i = '0;
      slv_ready   = 1'b0;
      chk("single_grant_c5", 32'(grant_o), 32'h0);
      tick();

      // Contention with an always-ready slave: 0,1,0,1 with a bubble between.
      do_reset();
      cont_exp = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
      mst_valid_i = 2'b11;
      slv_ready   = 1'b1;
      slv_rdata   = 32'h0000_00C0;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk($sformatf("cont_grant_c%0d", i + 1), 32'(grant_o), 32'(cont_exp[i]));
         chk($sformatf("cont_ready_c%0d", i + 1), 32'(mst_ready_o), 32'(cont_exp[i]));
      end
      mst_valid_i = '0;
      slv_ready   = 1'b0;
      tick();

      // Write capture: master 1 changes its inputs while BUSY.
      mst_valid_i[1] = 1'b1;
      mst_addr_i[1]  = 32'h2000_0040;
      mst_wdata_i[1] = 32'hA5A5_0F0F;
      mst_wstrb_i[1] = 4'b0011;
      tick();
      chk("wr_grant", 32'(grant_o), 32'h2);
      mst_addr_i[1]  = 32'h0;
      mst_wdata_i[1] = 32'hFFFF_FFFF;
      mst_wstrb_i[1] = 4'b1100;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("wr_wdata_hold", nmi.wdata, 32'hA5A5_0F0F);
         chk("wr_wstrb_hold", 32'(nmi.wstrb), 32'h3);
         chk("wr_addr_hold", nmi.addr, 32'h2000_0040);
      end
      slv_ready = 1'b1;
      slv_rdata = 32'h0;
      #1;
      chk("wr_ready", 32'(mst_ready_o), 32'h2);
      tick();
      mst_valid_i = '0;
      slv_ready   = 1'b0;
      mst_wstrb_i = '0;
      tick();

      // Reset while BUSY with master 0 as last winner.
      mst_valid_i[0] = 1'b1;
      mst_addr_i[0]  = 32'h3000_0000;
      tick();
      chk("mrst_grant_pre", 32'(grant_o), 32'h1);
      tick();
      slv_ready = 1'b1;
      rst_n_i   = 1'b0;
      #1;
      chk("mrst_valid", 32'(nmi.valid), 32'h0);
      chk("mrst_grant", 32'(grant_o), 32'h0);
      chk("mrst_ready", 32'(mst_ready_o), 32'h0);
      chk("mrst_addr", nmi.addr, 32'h0);
      slv_ready   = 1'b0;
      mst_valid_i = 2'b11;
      tick();
      rst_n_i = 1'b1;
      tick();
      chk("mrst_prio0", 32'(grant_o), 32'h1);
      slv_ready   = 1'b1;
      mst_valid_i = '0;
      tick();
      slv_ready = 1'b0;
      chk("mrst_done", 32'(grant_o), 32'h0);

      // Slave never ready; master 1 is next in turn.
      mst_valid_i = 2'b11;
      slv_rdata   = 32'h0BAD_F00D;
      tick();
      chk("wd_grant_c1", 32'(grant_o), 32'h2);
`ifdef NMI_ARB_TIMEOUT_EN
      for (int i = 0; i < 15; i++) tick();
      chk("wd_ready_c16", 32'(mst_ready_o), 32'h2);
      chk("wd_tmo_c16", 32'(tmo_o), 32'h1);
      chk("wd_rdata_c16", mst_rdata_o, 32'hDEAD_BEEF);
      tick();
      mst_valid_i[1] = 1'b0;
      chk("wd_idle_c17", 32'(grant_o), 32'h0);
      chk("wd_valid_c17", 32'(nmi.valid), 32'h0);
      tick();
      chk("wd_grant_c18", 32'(grant_o), 32'h1);
      for (int i = 0; i < 15; i++) tick();
      slv_ready = 1'b1;
      #1;
      chk("wd_race_ready", 32'(mst_ready_o), 32'h1);
      chk("wd_race_tmo", 32'(tmo_o), 32'h0);
      chk("wd_race_rdata", mst_rdata_o, 32'h0BAD_F00D);
      tick();
      mst_valid_i = '0;
      slv_ready   = 1'b0;
      tick();
`else
      n_done = 0;
      n_tmo  = 0;
      for (int i = 0; i < 10000; i++) begin
         tick();
         if (mst_ready_o != '0) n_done++;
         if (tmo_o) n_tmo++;
      end
      chk("nowd_completions", 32'(n_done), 32'h0);
      chk("nowd_tmo", 32'(n_tmo), 32'h0);
      chk("nowd_grant", 32'(grant_o), 32'h2);
      mst_valid_i = '0;
      do_reset();
      tick();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
